ram_arbiter: RTL and testbench



---
 rtl/ram_arbiter_pkg.sv | 19 +
 rtl/ram_arbiter_if.sv | 36 +++
 rtl/ram_arbiter.sv | 89 ++++++++
 tb/tb_ram_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-port RAM arbiter: widths, owner tags and the
// command bundle that is registered toward the RAM.
package ram_arbiter_pkg;

   localparam int ADDR_W = 15;
   localparam int DATA_W = 8;

   typedef enum logic {
      OWN_A = 1'b0,
      OWN_B = 1'b1
   } owner_e;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] din;
   } ram_cmd_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side bundle for both arbiter ports. The master modport is the
// requester view and the slave modport is the arbiter view.
interface ram_arbiter_if;
   import ram_arbiter_pkg::*;

   logic              a_req;
   logic              a_we;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_din;
   logic              a_ack;
   logic              a_rvalid;
   logic [DATA_W-1:0] a_rdata;

   logic              b_req;
   logic              b_we;
   logic [ADDR_W-1:0] b_addr;
   logic [DATA_W-1:0] b_din;
   logic              b_ack;
   logic              b_rvalid;
   logic [DATA_W-1:0] b_rdata;

   modport master (
      output a_req, a_we, a_addr, a_din,
      input  a_ack, a_rvalid, a_rdata,
      output b_req, b_we, b_addr, b_din,
      input  b_ack, b_rvalid, b_rdata
   );

   modport slave (
      input  a_req, a_we, a_addr, a_din,
      output a_ack, a_rvalid, a_rdata,
      input  b_req, b_we, b_addr, b_din,
      output b_ack, b_rvalid, b_rdata
   );

endinterface

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port 32 kB synchronous RAM. Acks are
// combinational, the RAM command is registered and read data returns 2 cycles after ack.
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int PRIO_MODE  = 0,
   parameter int STARVE_MAX = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   ram_arbiter_if.slave      bus,
   output logic              ram_sel,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout
);

   localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

   owner_e     last_grant;
   logic [7:0] starve_cnt;
   logic       grant_b;
   logic       a_ack;
   logic       b_ack;
   logic       any_ack;
   ram_cmd_t   win_cmd;

   // Read-return pipeline: stage 1 lines up with ram_sel, stage 2 with ram_dout.
   logic       rd_s1;
   logic       rd_s2;
   owner_e     own_s1;
   owner_e     own_s2;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      grant_b = bus.b_req;
      if (bus.a_req && bus.b_req) begin
         if (PRIO_MODE == 0) grant_b = (last_grant == OWN_A);
         else                grant_b = (starve_cnt == STARVE_LIM);
      end
      // Acks are gated by rst_n so neither port sees an accept while reset is held.
      a_ack   = rst_n && bus.a_req && !grant_b;
      b_ack   = rst_n && bus.b_req && grant_b;
      any_ack = a_ack || b_ack;
      if (b_ack) win_cmd = '{we: bus.b_we, addr: bus.b_addr, din: bus.b_din};
      else       win_cmd = '{we: bus.a_we, addr: bus.a_addr, din: bus.a_din};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ram_sel    <= 1'b0;
         ram_we     <= 1'b0;
         ram_addr   <= '0;
         ram_din    <= '0;
         last_grant <= OWN_B;
         starve_cnt <= '0;
         rd_s1      <= 1'b0;
         rd_s2      <= 1'b0;
         own_s1     <= OWN_A;
         own_s2     <= OWN_A;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         ram_sel <= any_ack;
         ram_we  <= any_ack && win_cmd.we;
         if (any_ack) begin
            ram_addr   <= win_cmd.addr;
            ram_din    <= win_cmd.din;
            last_grant <= b_ack ? OWN_B : OWN_A;
         end

         if (b_ack)                                    starve_cnt <= '0;
         else if (bus.b_req && starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 8'd1;

         rd_s1  <= any_ack && !win_cmd.we;
         own_s1 <= b_ack ? OWN_B : OWN_A;
         rd_s2  <= rd_s1;
         own_s2 <= own_s1;
      end
   end

   assign bus.a_ack    = a_ack;
   assign bus.b_ack    = b_ack;
   assign bus.a_rvalid = rd_s2 && (own_s2 == OWN_A);
   assign bus.b_rvalid = rd_s2 && (own_s2 == OWN_B);
   assign bus.a_rdata  = ram_dout;
   assign bus.b_rdata  = ram_dout;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed and random checks of ram_arbiter: one round-robin instance and one
// fixed-priority instance (STARVE_MAX=3) fed the same requester inputs.
module tb_ram_arbiter;
   import ram_arbiter_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   ram_arbiter_if bus_r ();
   ram_arbiter_if bus_p ();

   logic              sel_r, we_r, sel_p, we_p;
   logic [ADDR_W-1:0] addr_r, addr_p;
   logic [DATA_W-1:0] din_r, din_p;
   logic [DATA_W-1:0] dout_r = '0;
   logic [DATA_W-1:0] dout_p = '0;

   ram_arbiter #(.PRIO_MODE(0), .STARVE_MAX(8)) dut_rr (
      .clk(clk), .rst_n(rst_n), .bus(bus_r),
      .ram_sel(sel_r), .ram_we(we_r), .ram_addr(addr_r), .ram_din(din_r), .ram_dout(dout_r)
   );

   ram_arbiter #(.PRIO_MODE(1), .STARVE_MAX(3)) dut_pr (
      .clk(clk), .rst_n(rst_n), .bus(bus_p),
      .ram_sel(sel_p), .ram_we(we_p), .ram_addr(addr_p), .ram_din(din_p), .ram_dout(dout_p)
   );

   assign bus_p.a_req  = bus_r.a_req;
   assign bus_p.a_we   = bus_r.a_we;
   assign bus_p.a_addr = bus_r.a_addr;
   assign bus_p.a_din  = bus_r.a_din;
   assign bus_p.b_req  = bus_r.b_req;
   assign bus_p.b_we   = bus_r.b_we;
   assign bus_p.b_addr = bus_r.b_addr;
   assign bus_p.b_din  = bus_r.b_din;

   // Unwritten RAM locations read back a fixed address-derived pattern.
   function automatic logic [7:0] pre(input logic [14:0] a);
      return a[7:0] + {1'b0, a[14:8]};
   endfunction

   logic [7:0] mem_r [0:32767];
   bit         wr_r  [0:32767];
   logic [7:0] mem_p [0:32767];
   bit         wr_p  [0:32767];

   always @(posedge clk) begin
      if (sel_r) begin
         if (we_r) begin
            mem_r[addr_r] <= din_r;
            wr_r[addr_r]  <= 1'b1;
         end else dout_r <= wr_r[addr_r] ? mem_r[addr_r] : pre(addr_r);
      end
   end

   always @(posedge clk) begin
      if (sel_p) begin
         if (we_p) begin
            mem_p[addr_p] <= din_p;
            wr_p[addr_p]  <= 1'b1;
         end else dout_p <= wr_p[addr_p] ? mem_p[addr_p] : pre(addr_p);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive_a(input logic req, input logic we, input logic [14:0] addr, input logic [7:0] din);
      bus_r.a_req  = req;
      bus_r.a_we   = we;
      bus_r.a_addr = addr;
      bus_r.a_din  = din;
   endtask

   task automatic drive_b(input logic req, input logic we, input logic [14:0] addr, input logic [7:0] din);
      bus_r.b_req  = req;
      bus_r.b_we   = we;
      bus_r.b_addr = addr;
      bus_r.b_din  = din;
   endtask

   typedef struct {
      owner_e     own;
      logic [7:0] data;
      int         cyc;
   } rd_t;

   rd_t        rq[$];
   logic [7:0] em [0:32767];
   bit         ew [0:32767];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      owner_e      m_last;
      logic        ea, eb, a_done, b_done;
      int          n_ack, n_sel;
      logic [14:0] ra;
      rd_t         e;

      drive_a(1'b0, 1'b0, '0, '0);
      drive_b(1'b0, 1'b0, '0, '0);

      // Reset state, with a request held to show ack stays low.
      repeat (2) @(negedge clk);
      drive_a(1'b1, 1'b0, 15'h1234, 8'h00);
      #1;
      check("rst_a_ack", bus_r.a_ack, 0);
      check("rst_ram_sel", sel_r, 0);
      check("rst_ram_we", we_r, 0);
      check("rst_ram_addr", addr_r, 0);
      check("rst_ram_din", din_r, 0);
      check("rst_a_rvalid", bus_r.a_rvalid, 0);
      check("rst_b_rvalid", bus_r.b_rvalid, 0);

      // Single A read acked in the first cycle after release.
      @(negedge clk); rst_n = 1'b1; #1;
      check("rd_a_ack", bus_r.a_ack, 1);
      check("rd_b_ack", bus_r.b_ack, 0);
      @(negedge clk); drive_a(1'b0, 1'b0, '0, '0); #1;
      check("rd_ram_sel", sel_r, 1);
      check("rd_ram_addr", addr_r, 15'h1234);
      check("rd_ram_we", we_r, 0);
      @(negedge clk); #1;
      check("rd_a_rvalid", bus_r.a_rvalid, 1);
      check("rd_a_rdata", bus_r.a_rdata, 8'h46);
      check("rd_b_rvalid", bus_r.b_rvalid, 0);
      check("idle_ram_sel", sel_r, 0);
      check("idle_addr_hold", addr_r, 15'h1234);
      @(negedge clk); #1;
      check("rd_rvalid_1cyc", bus_r.a_rvalid, 0);

      // A writes 0xA5 to 0x7FFF, B reads it back next cycle.
      @(negedge clk); drive_a(1'b1, 1'b1, 15'h7FFF, 8'hA5); #1;
      check("wr_a_ack", bus_r.a_ack, 1);
      @(negedge clk); drive_a(1'b0, 1'b0, '0, '0); drive_b(1'b1, 1'b0, 15'h7FFF, 8'h00); #1;
      check("wr_b_ack", bus_r.b_ack, 1);
      check("wr_ram_sel", sel_r, 1);
      check("wr_ram_we", we_r, 1);
      check("wr_ram_addr", addr_r, 15'h7FFF);
      check("wr_ram_din", din_r, 8'hA5);
      @(negedge clk); drive_b(1'b0, 1'b0, '0, '0); #1;
      check("wr_rd_sel", sel_r, 1);
      check("wr_rd_we", we_r, 0);
      check("wr_no_rvalid", bus_r.a_rvalid, 0);
      @(negedge clk); #1;
      check("wr_b_rvalid", bus_r.b_rvalid, 1);
      check("wr_b_rdata", bus_r.b_rdata, 8'hA5);
      check("wr_a_rvalid", bus_r.a_rvalid, 0);

      // Both ports requesting: round-robin alternates, priority gives A,A,A,B.
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (k < 8) begin
            drive_a(1'b1, 1'b0, 15'h0010, 8'h00);
            drive_b(1'b1, 1'b0, 15'h0020, 8'h00);
         end else begin
            drive_a(1'b0, 1'b0, '0, '0);
            drive_b(1'b0, 1'b0, '0, '0);
         end
         #1;
         if (k < 8) begin
            check("rr_a_ack", bus_r.a_ack, (k % 2 == 0));
            check("rr_b_ack", bus_r.b_ack, (k % 2 == 1));
            check("pr_a_ack", bus_p.a_ack, (k % 4 != 3));
            check("pr_b_ack", bus_p.b_ack, (k % 4 == 3));
            check("pr_starve_cnt", dut_pr.starve_cnt, k % 4);
         end
         if (k >= 2) begin
            check("rr_a_rvalid", bus_r.a_rvalid, (k % 2 == 0));
            check("rr_b_rvalid", bus_r.b_rvalid, (k % 2 == 1));
            if (k % 2 == 0) check("rr_a_rdata", bus_r.a_rdata, 8'h10);
            else            check("rr_b_rdata", bus_r.b_rdata, 8'h20);
         end
         if (k == 5) check("pr_b_rvalid", bus_p.b_rvalid, 1);
      end

      // Reset asserted while a read is in flight.
      @(negedge clk); drive_a(1'b1, 1'b0, 15'h0042, 8'h00); #1;
      check("rm_a_ack", bus_r.a_ack, 1);
      @(negedge clk); rst_n = 1'b0; #1;
      check("rm_a_ack_forced", bus_r.a_ack, 0);
      check("rm_b_ack_forced", bus_r.b_ack, 0);
      check("rm_ram_sel", sel_r, 0);
      check("rm_ram_we", we_r, 0);
      check("rm_ram_addr", addr_r, 0);
      check("rm_ram_din", din_r, 0);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk); #1;
         check("rm_a_rvalid", bus_r.a_rvalid, 0);
         check("rm_b_rvalid", bus_r.b_rvalid, 0);
      end
      @(negedge clk); rst_n = 1'b1; #1;
      check("rm_rel_a_ack", bus_r.a_ack, 1);
      check("rm_rel_a_rvalid", bus_r.a_rvalid, 0);
      @(negedge clk); drive_a(1'b0, 1'b0, '0, '0); #1;
      check("rm_rel_sel", sel_r, 1);
      @(negedge clk); #1;
      check("rm_rel_rvalid", bus_r.a_rvalid, 1);
      check("rm_rel_rdata", bus_r.a_rdata, 8'h42);

      // Random two-port traffic against a byte-array model; the last grant above was A.
      m_last = OWN_A;
      a_done = 1'b0;
      b_done = 1'b0;
      n_ack  = 0;
      n_sel  = 0;
      for (int c = 0; c < 10003; c++) begin
         @(negedge clk);
         if (c >= 10000) begin
            drive_a(1'b0, 1'b0, '0, '0);
            drive_b(1'b0, 1'b0, '0, '0);
         end else begin
            if (!bus_r.a_req || a_done) begin
               ra = 15'h7F00 + 15'($urandom_range(0, 31));
               drive_a($urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0, ra, 8'($urandom));
            end
            if (!bus_r.b_req || b_done) begin
               ra = 15'h7F00 + 15'($urandom_range(0, 31));
               drive_b($urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0, ra, 8'($urandom));
            end
         end
         #1;
         ea = bus_r.a_req && (!bus_r.b_req || m_last == OWN_B);
         eb = bus_r.b_req && !ea;
         check("rnd_a_ack", bus_r.a_ack, ea);
         check("rnd_b_ack", bus_r.b_ack, eb);
         if (ea || eb) begin
            n_ack++;
            m_last = ea ? OWN_A : OWN_B;
            ra = ea ? bus_r.a_addr : bus_r.b_addr;
            if (ea ? bus_r.a_we : bus_r.b_we) begin
               em[ra] = ea ? bus_r.a_din : bus_r.b_din;
               ew[ra] = 1'b1;
            end else begin
               e.own  = m_last;
               e.data = ew[ra] ? em[ra] : pre(ra);
               e.cyc  = c;
               rq.push_back(e);
            end
         end
         if (sel_r) n_sel++;
         if (bus_r.a_rvalid || bus_r.b_rvalid) begin
            check("rnd_rvalid_excl", bus_r.a_rvalid && bus_r.b_rvalid, 0);
            if (rq.size() == 0) check("rnd_extra_rvalid", 1, 0);
            else begin
               e = rq.pop_front();
               check("rnd_rv_owner", bus_r.b_rvalid, e.own == OWN_B);
               check("rnd_rv_latency", c - e.cyc, 2);
               check("rnd_rdata", bus_r.a_rvalid ? bus_r.a_rdata : bus_r.b_rdata, e.data);
            end
         end
         a_done = ea;
         b_done = eb;
      end
      check("rnd_lost_reads", rq.size(), 0);
      check("rnd_sel_count", n_sel, n_ack);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
